// File: rtl/inv_round_engine_if.sv
// Ciphertext-in / plaintext-out handshake plus the round-key lookup bus of the
// AES-128 decrypt engine. The engine side is the slave modport.
interface inv_round_engine_if;
    // valid/ready: a word moves on a rising clk edge where valid and ready are
    // both high; valid is never withdrawn by the engine before that edge, and
    // ready carries no obligation for the other side while valid is low.
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [1:0]   fsm_state;

    modport slave (
        input  in_valid, in_data, rk, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy, fsm_state
    );

    modport master (
        output in_valid, in_data, rk, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy, fsm_state
    );
endinterface

// File: rtl/inv_round_engine.sv
// Iterative AES-128 inverse cipher: one round per clock through a single shared
// round-logic instance, round keys fetched from an external store via rk_idx.
module inv_round_engine #(
    parameter int NR = 10
) (
    input logic              clk,
    input logic              rst,
    inv_round_engine_if.slave bus
);

    if (NR != 10) begin : g_nr_check
        $error("inv_round_engine supports only NR = 10 (AES-128)");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    // Byte k sits at row k%4, column k/4; row n rotates right by n.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = inv_sub(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    state_t       state;
    state_t       state_next;
    logic [3:0]   r;
    logic [127:0] st;
    logic [127:0] out_data_q;
    logic [127:0] round_out;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [3:0]   rk_idx;
    logic         accept;

    // Shared round logic; InvMixColumns is applied only on non-final rounds.
    assign round_out = inv_shift_sub(st) ^ bus.rk;
    assign accept    = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ROUND;
            ROUND:   if (r == 4'd0) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'(NR);
        case (state)
            IDLE:    in_ready = 1'b1;
            ROUND: begin
                busy   = 1'b1;
                rk_idx = r;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= '0;
            r          <= '0;
            out_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        st <= bus.in_data ^ bus.rk;
                        r  <= 4'(NR - 1);
                    end
                end
                ROUND: begin
                    if (r != 4'd0) begin
                        st <= inv_mix(round_out);
                        r  <= r - 4'd1;
                    end else begin
                        out_data_q <= round_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.rk_idx    = rk_idx;
    assign bus.out_data  = out_data_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_inv_round_engine.sv
// Bench for inv_round_engine: FIPS-197 vectors, backpressure, rk_idx trace,
// mid-block reset and 200 random blocks against a behavioural AES-128 decrypt model.
module tb_inv_round_engine;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    inv_round_engine_if bus ();

    inv_round_engine #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [127:0] key_store [16];
    assign bus.rk = key_store[bus.rk_idx];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] cur_key  = '0;
    logic [127:0] exp_q[$];
    int           m_mode      = M_IDLE;
    int           m_left      = 0;
    logic [127:0] m_out       = '0;
    int           m_accepted  = 0;
    int           m_delivered = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model_round_key(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Textbook inverse cipher on a 4x4 byte matrix s[row][col].
    function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [127:0] rk;
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        rk = model_round_key(key, 10);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ rk[127 - 8*(4*c + r) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            rk = model_round_key(key, rnd);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = inv_sbox[s[r][(c - r + 4) % 4]] ^ rk[127 - 8*(4*c + r) -: 8];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd > 0) begin
                        s[r][c] = 8'h00;
                        for (int k = 0; k < 4; k++) s[r][c] = s[r][c] ^ gmul(t[k][c], coef[(k - r + 4) % 4]);
                    end else begin
                        s[r][c] = t[r][c];
                    end
                end
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    // Reference timeline: accept, ten round cycles, then hold until out_ready.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = M_IDLE;
            m_left = 0;
            m_out  = '0;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (bus.in_valid) begin
                    exp_q.push_back(model_decrypt(cur_key, bus.in_data));
                    m_accepted++;
                    m_mode = M_BUSY;
                    m_left = 10;
                end
                M_BUSY: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_DONE;
                        m_out  = exp_q[0];
                    end
                end
                default: if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    m_delivered++;
                    m_mode = M_IDLE;
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        check("in_ready", 128'(bus.in_ready), 128'(m_mode == M_IDLE));
        check("busy", 128'(bus.busy), 128'(m_mode == M_BUSY));
        check("out_valid", 128'(bus.out_valid), 128'(m_mode == M_DONE));
        check("out_data", bus.out_data, m_out);
        if (m_mode != M_DONE)
            check("rk_idx", 128'(bus.rk_idx), 128'(m_mode == M_BUSY ? m_left - 1 : 10));
    end

    task automatic send_block(input logic [127:0] key, input logic [127:0] ct);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("in_ready_timeout", 128'(bus.in_ready), 128'(1));
            return;
        end
        cur_key = key;
        for (int i = 0; i <= 10; i++) key_store[i] = model_round_key(key, i);
        bus.in_data  = ct;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!bus.out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_timeout", 128'(bus.out_valid), 128'(1));
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           stable;
        int           busy_cnt;
        int           idle_cnt;
        int           acc0;
        int           del0;
        int           t;
        logic         stop;
        logic [3:0]   trace [13];
        logic [127:0] got;
        logic [7:0]   inv;
        logic [7:0]   s;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
        for (int i = 0; i < 16; i++) key_store[i] = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_in_ready", 128'(bus.in_ready), 128'(1));
        check("reset_out_valid", 128'(bus.out_valid), 128'(0));
        check("reset_busy", 128'(bus.busy), 128'(0));
        check("reset_rk_idx", 128'(bus.rk_idx), 128'(10));
        check("reset_out_data", bus.out_data, 128'(0));
        rst = 1'b0;

        check("model_fips_b", model_decrypt(K1, CT1), PT1);
        check("model_fips_c1", model_decrypt(K2, CT2), PT2);

        // FIPS-197 B with latency count, then 20 cycles of backpressure.
        send_block(K1, CT1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_edges", 128'(lat), 128'(10));
        check("fips_b_out", bus.out_data, PT1);
        stable = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid && !bus.in_ready && bus.out_data == PT1) stable++;
        end
        check("backpressure_stable", 128'(stable), 128'(20));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 128'(bus.in_ready), 128'(1));
        check("release_out_valid", 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        bus.out_ready = 1'b0;

        // FIPS-197 C.1 with rk_idx trace.
        bus.out_ready = 1'b1;
        @(negedge clk);
        cur_key = K2;
        for (int i = 0; i <= 10; i++) key_store[i] = model_round_key(K2, i);
        bus.in_data  = CT2;
        bus.in_valid = 1'b1;
        trace[0] = bus.rk_idx;
        busy_cnt = 0;
        got      = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            trace[k] = bus.rk_idx;
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) got = bus.out_data;
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k <= 10; k++) check($sformatf("rk_trace_%0d", k), 128'(trace[k]), 128'(10 - k));
        check("rk_trace_idle", 128'(trace[12]), 128'(10));
        check("busy_cycles", 128'(busy_cnt), 128'(10));
        check("fips_c1_out", got, PT2);

        // in_valid raised mid-block must be neither taken nor queued.
        send_block(K2, CT2);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out();
        check("busy_ignore_out", bus.out_data, PT2);
        take_out();
        idle_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.in_ready && !bus.out_valid) idle_cnt++;
        end
        check("no_queued_block", 128'(idle_cnt), 128'(15));

        // Reset while r = 5, then a clean rerun of FIPS-197 B.
        send_block(K1, CT1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_at_r5", 128'(bus.rk_idx), 128'(5));
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_out_data", bus.out_data, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        send_block(K1, CT1);
        wait_out();
        check("rerun_fips_b", bus.out_data, PT1);
        take_out();

        // 200 random key/ciphertext pairs with random gaps and random out_ready.
        acc0 = m_accepted;
        del0 = m_delivered;
        stop = 1'b0;
        fork
            begin
                for (int b = 0; b < 200; b++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send_block({$urandom(), $urandom(), $urandom(), $urandom()},
                               {$urandom(), $urandom(), $urandom(), $urandom()});
                end
                t = 0;
                while (m_delivered - del0 < 200 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        bus.out_ready = 1'b0;
        check("random_accepted", 128'(m_accepted - acc0), 128'(200));
        check("random_delivered", 128'(m_delivered - del0), 128'(200));
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
